// File: rtl/oh_pktmux_pkg.sv
// Shared definitions for the packet-locking N:1 multiplexer.
// The state encoding is fixed so that other blocks and debug tools can decode it.
package oh_pktmux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/oh_arbiter.sv
// Combinational one-hot arbiter. "FIXED" grants the lowest set request and
// "FIXED_MSB" grants the highest; any other TYPE value falls back to "FIXED".
module oh_arbiter #(
  parameter int    N    = 4,
  parameter string TYPE = "FIXED"
) (
  input  logic [N-1:0] requests,
  output logic [N-1:0] grants
);

  generate
    if (TYPE == "FIXED_MSB") begin : g_msb
      always_comb begin
        grants = '0;
        for (int i = 0; i < N; i++) begin
          if (requests[i]) begin
            grants    = '0;
            grants[i] = 1'b1;
          end
        end
      end
    end else begin : g_lsb
      // Isolating the lowest set bit gives lowest-index-wins in one expression.
      assign grants = requests & (~requests + {{(N-1){1'b0}}, 1'b1});
    end
  endgenerate

endmodule

// File: rtl/oh_pktmux.sv
// Packet-level N:1 mux: a fixed-priority grant is locked for a whole packet
// and the locked channel's beats drain through one registered output stage.
module oh_pktmux
  import oh_pktmux_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [N-1:0]    out_src,
  input  logic            out_ready,
  output logic            busy
);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  lock;
  logic [N-1:0]  lock_nxt;
  logic [N-1:0]  grant;
  logic          can_load;
  logic          accept;
  logic [DW-1:0] sel_data;
  logic          sel_last;

  oh_arbiter #(
    .N    (N),
    .TYPE ("FIXED")
  ) u_arbiter (
    .requests (in_valid),
    .grants   (grant)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign can_load = ~out_valid | out_ready;
  assign in_ready = (state == LOCKED && !reset) ? (lock & {N{can_load}}) : '0;
  assign accept   = |(in_valid & in_ready);
  assign busy     = (state == LOCKED);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (lock[i]) begin
        sel_data = sel_data | in_data[i*DW +: DW];
      end
    end
  end

  assign sel_last = |(in_last & lock);

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock;
    case (state)
      IDLE: begin
        if (|in_valid) begin
          lock_nxt  = grant;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          lock_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        lock_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lock  <= '0;
    end else begin
      state <= state_nxt;
      lock  <= lock_nxt;
    end
  end

  // A new beat overwrites the register even while the old one drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= lock;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oh_pktmux.sv
// Self-checking bench for oh_pktmux: directed scenarios plus random traffic,
// all compared cycle by cycle against a packet-level reference model.
module tb_oh_pktmux;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [N-1:0]    out_src;
  logic            out_ready;
  logic            busy;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic [N-1:0]  src;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } xfer_t;

  beat_t srcQ[N][$];
  xfer_t outLog[$];

  int assertCount = 0;
  int failCount   = 0;
  int cycleNum    = 0;

  int            mOwner;
  logic          mOutValid;
  logic [DW-1:0] mOutData;
  logic          mOutLast;
  int            mOutSrc;

  oh_pktmux #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  function automatic logic [N-1:0] chanMask(input int ch);
    logic [N-1:0] m;
    m = '0;
    if (ch >= 0) m[ch] = 1'b1;
    return m;
  endfunction

  task automatic modelReset();
    mOwner    = -1;
    mOutValid = 1'b0;
    mOutData  = '0;
    mOutLast  = 1'b0;
    mOutSrc   = -1;
  endtask

  task automatic pushBeat(input int ch, input logic [DW-1:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    srcQ[ch].push_back(b);
  endtask

  // One clock cycle: drive sources, compare the DUT to the model, advance the model.
  task automatic applyStimulus(input logic [N-1:0] allow, input logic oready);
    logic [N-1:0] expReady;
    logic         acc;
    beat_t        b;
    int           low;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = oready;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = allow[i] && (srcQ[i].size() > 0);
      if (in_valid[i]) begin
        in_data[i*DW +: DW] = srcQ[i][0].data;
        in_last[i]          = srcQ[i][0].last;
      end else begin
        in_data[i*DW +: DW] = $urandom;
        in_last[i]          = 1'($urandom);
      end
    end
    #1;
    expReady = '0;
    if (mOwner >= 0 && (!mOutValid || oready)) expReady[mOwner] = 1'b1;
    checkOutput("in_ready", 64'(in_ready), 64'(expReady));
    checkOutput("busy", 64'(busy), 64'(mOwner >= 0));
    checkOutput("out_valid", 64'(out_valid), 64'(mOutValid));
    if (mOutValid) begin
      checkOutput("out_data", 64'(out_data), 64'(mOutData));
      checkOutput("out_last", 64'(out_last), 64'(mOutLast));
      checkOutput("out_src", 64'(out_src), 64'(chanMask(mOutSrc)));
    end
    if (out_valid && oready) begin
      outLog.push_back('{src: out_src, data: out_data, last: out_last, cyc: cycleNum});
    end
    acc = (mOwner >= 0) && in_valid[mOwner] && expReady[mOwner];
    if (acc) begin
      b         = srcQ[mOwner].pop_front();
      mOutValid = 1'b1;
      mOutData  = b.data;
      mOutLast  = b.last;
      mOutSrc   = mOwner;
      if (b.last) mOwner = -1;
    end else begin
      if (mOutValid && oready) mOutValid = 1'b0;
      if (mOwner < 0) begin
        low = -1;
        for (int i = N - 1; i >= 0; i--) if (in_valid[i]) low = i;
        mOwner = low;
      end
    end
    cycleNum++;
  endtask

  task automatic doReset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'($urandom);
      #1;
      checkOutput("in_ready_in_reset", 64'(in_ready), 64'(0));
      cycleNum++;
    end
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_out_last", 64'(out_last), 64'(0));
    checkOutput("rst_out_src", 64'(out_src), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
  endtask

  task automatic checkLog(input string tag, input int idx, input logic [N-1:0] src,
                          input logic [DW-1:0] data, input logic last);
    if (idx < outLog.size()) begin
      checkOutput({tag, "_src"}, 64'(outLog[idx].src), 64'(src));
      checkOutput({tag, "_data"}, 64'(outLog[idx].data), 64'(data));
      checkOutput({tag, "_last"}, 64'(outLog[idx].last), 64'(last));
    end else begin
      checkOutput({tag, "_missing"}, 64'(outLog.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int total;
    int pending;
    int drained;
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b0;
    modelReset();

    $display("[TB] reset and idle");
    doReset(3);
    for (int c = 0; c < 4; c++) applyStimulus('0, 1'b1);

    $display("[TB] priority");
    outLog.delete();
    pushBeat(1, 32'hA1, 1'b0); pushBeat(1, 32'hA2, 1'b1);
    pushBeat(3, 32'hC1, 1'b0); pushBeat(3, 32'hC2, 1'b1);
    for (int c = 0; c < 10; c++) applyStimulus(4'b1010, 1'b1);
    checkOutput("prio_count", 64'(outLog.size()), 64'(4));
    checkLog("prio0", 0, 4'b0010, 32'hA1, 1'b0);
    checkLog("prio1", 1, 4'b0010, 32'hA2, 1'b1);
    checkLog("prio2", 2, 4'b1000, 32'hC1, 1'b0);
    checkLog("prio3", 3, 4'b1000, 32'hC2, 1'b1);
    if (outLog.size() >= 3) checkOutput("prio_bubble", 64'(outLog[2].cyc - outLog[1].cyc), 64'(2));

    $display("[TB] lock hold");
    outLog.delete();
    pushBeat(2, 32'h54, 1'b0); pushBeat(2, 32'h55, 1'b1);
    pushBeat(0, 32'h0E, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("hold_no_output", 64'(outLog.size()), 64'(1));
    for (int c = 0; c < 8; c++) applyStimulus(4'b0101, 1'b1);
    checkLog("hold0", 0, 4'b0100, 32'h54, 1'b0);
    checkLog("hold1", 1, 4'b0100, 32'h55, 1'b1);
    checkLog("hold2", 2, 4'b0001, 32'h0E, 1'b1);

    $display("[TB] back-pressure");
    outLog.delete();
    for (int k = 0; k < 4; k++) pushBeat(0, 32'h10 + 32'(k), k == 3);
    for (int c = 0; c < 20; c++) applyStimulus(4'b0001, (c % 4 == 0) || (c % 4 == 3));
    checkOutput("bp_count", 64'(outLog.size()), 64'(4));
    for (int k = 0; k < 4; k++) checkLog("bp", k, 4'b0001, 32'h10 + 32'(k), k == 3);

    $display("[TB] single-beat packets");
    outLog.delete();
    for (int k = 1; k <= 3; k++) pushBeat(1, 32'(k), 1'b1);
    for (int c = 0; c < 9; c++) applyStimulus(4'b0010, 1'b1);
    checkOutput("single_count", 64'(outLog.size()), 64'(3));
    for (int k = 0; k < 3; k++) checkLog("single", k, 4'b0010, 32'(k + 1), 1'b1);
    for (int k = 1; k < 3 && k < outLog.size(); k++)
      checkOutput("single_spacing", 64'(outLog[k].cyc - outLog[k-1].cyc), 64'(2));

    $display("[TB] reset mid-packet");
    outLog.delete();
    for (int k = 0; k < 4; k++) pushBeat(3, 32'h30 + 32'(k), k == 3);
    for (int c = 0; c < 3; c++) applyStimulus(4'b1000, 1'b1);
    for (int i = 0; i < N; i++) srcQ[i].delete();
    doReset(1);
    outLog.delete();
    pushBeat(0, 32'h77, 1'b1);
    for (int c = 0; c < 5; c++) applyStimulus(4'b0001, 1'b1);
    checkOutput("rst_mid_count", 64'(outLog.size()), 64'(1));
    checkLog("rst_mid", 0, 4'b0001, 32'h77, 1'b1);

    $display("[TB] random traffic");
    outLog.delete();
    total = 0;
    for (int ch = 0; ch < N; ch++) begin
      for (int p = 0; p < 10; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          pushBeat(ch, {8'(ch), 8'(p), 8'(b), 8'($urandom)}, b == len - 1);
          total++;
        end
      end
    end
    for (int c = 0; c < 600; c++) applyStimulus(4'($urandom), $urandom_range(0, 3) != 0);
    drained = 0;
    pending = 1;
    while (pending != 0 && drained < 600) begin
      applyStimulus('1, 1'b1);
      drained++;
      pending = (mOwner >= 0 || mOutValid) ? 1 : 0;
      for (int i = 0; i < N; i++) pending += srcQ[i].size();
    end
    checkOutput("rand_drain_left", 64'(pending), 64'(0));
    checkOutput("rand_total", 64'(outLog.size()), 64'(total));
    for (int k = 1; k < outLog.size(); k++) begin
      if (!outLog[k-1].last) checkOutput("rand_no_interleave", 64'(outLog[k].src), 64'(outLog[k-1].src));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/oh_pktmux.md
Name: oh_pktmux

Overview:
- Packet-level N:1 multiplexer that sits directly downstream of the fixed-priority arbiter.
- Arbitrates among N valid/ready input channels using a one-hot fixed-priority grant (lowest index wins) and locks that grant for a whole packet (until the beat with last).
- Forwards the packet through a single registered output stage.
- Used in front of shared links and memory ports where a multi-beat packet must never be interleaved with another source.

Parameters:
- N, 4: number of input channels (N >= 1).
- DW, 32: data width per beat.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel beat valid.
- in_data  input  N*DW  per-channel data; channel i occupies bits [i*DW +: DW].
- in_last  input  N  per-channel last-beat-of-packet flag.
- in_ready  output  N  per-channel ready; a beat transfers when in_valid[i] & in_ready[i].
- out_valid  output  1  registered output beat valid.
- out_data  output  DW  registered output data.
- out_last  output  1  registered last flag.
- out_src  output  N  one-hot source channel of the current out_data.
- out_ready  input  1  downstream ready; the output beat transfers when out_valid & out_ready.
- busy  output  1  high while a packet lock is held.

Behaviour:
- Reset: synchronous, active-high. All outputs and state are 0 after the clock edge with reset high: out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, lock=0, state=IDLE.
- in_ready is combinational from the lock and output state, so it is 0 during reset and on the cycle after.
- State machine, two states:
  - IDLE: in_ready=0. If |in_valid, lock <= fixed-priority grant of in_valid (lowest set index) and go to LOCKED. Otherwise stay in IDLE.
  - LOCKED: busy=1. in_ready = lock & {N{~out_valid | out_ready}}. All non-locked channels see in_ready=0.
- Transfer: an accepted beat from the locked channel k loads out_data=in_data[k], out_last=in_last[k], out_src=lock and sets out_valid=1, all on the next edge.
- Release: an accepted beat with in_last[k]=1 returns the FSM to IDLE and clears lock on the same edge.
- Output stage:
  - If out_valid & out_ready and no new beat is accepted, out_valid <= 0.
  - If a new beat is accepted in the same cycle the old one drains, the register reloads. This gives back-to-back throughput of 1 beat/cycle within a packet.
  - out_data, out_last and out_src hold their values while out_valid & ~out_ready.
- Latency:
  - in_valid first high in cycle 0 (FSM in IDLE) -> lock set at edge 1.
  - First beat accepted in cycle 1 -> out_valid high in cycle 2.
  - One bubble cycle (the IDLE arbitration cycle) between consecutive packets.
- Boundary conditions:
  - Locked channel drops in_valid mid-packet: lock is held and no transfer occurs. Other channels are starved until that packet's last beat.
  - Other channels asserting in_valid while LOCKED: ignored; no in_ready to them.
  - Single-beat packet (in_last=1 on the first beat): LOCKED for exactly one accepted beat, then IDLE.
  - Downstream back-pressure (out_ready=0 with out_valid=1): in_ready=0 on all channels. No beat is lost or duplicated.
  - Reset mid-packet: lock dropped, output register cleared, any in-flight output beat is discarded. Upstream is responsible for restarting its packet.
  - N=1: degenerates to a registered packet pipe with the one-cycle IDLE bubble.
- Fairness: fixed priority only. Starvation of high-index channels is permitted by design.

Decomposition:
- Shared package oh_pktmux_pkg: state encoding localparams IDLE=1'b0 and LOCKED=1'b1.
- Grant generation instantiates the existing oh_arbiter with TYPE="FIXED" and N=N; its requests input is in_valid.
- Data selection is a one-hot AND-OR mux on lock; it is local logic, not a separate module.

Test Plan:
- Reset and idle: hold reset for 3 cycles, then in_valid=0 -> out_valid=0, in_ready=0, busy=0 throughout.
- Priority: in_valid=4'b1010, each channel sends a 2-beat packet -> ch1 beats 0xA1, 0xA2 appear at the output first with out_src=0010, then after one bubble ch3 beats 0xC1, 0xC2 with out_src=1000.
- Lock hold: ch2 is locked and sends beat 1, then ch0 asserts in_valid while ch2 deasserts for 2 cycles -> in_ready[0]=0, no output for those cycles. ch2 resumes with last 0x55 -> out_data=0x55, out_last=1, then ch0 is granted.
- Back-pressure: 4-beat packet 0x10..0x13 on ch0 with out_ready toggling 1,0,0,1,... -> output order 0x10,0x11,0x12,0x13 exactly once each; data stable while stalled.
- Single-beat packets: ch1 streams 3 single-beat packets 0x01,0x02,0x03 with out_ready=1 -> outputs spaced 2 cycles apart, busy pulses once per packet.
- Reset mid-packet: assert reset after beat 2 of a 4-beat ch3 packet -> next cycle out_valid=0, busy=0, lock=0. After reset release, a new ch0 request is granted normally.
